// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame states, oversampling
// ratio and the baud divider calculation.
package uart_pkg;

  // Oversample ticks per bit period; mid-bit is reached after half of them.
  localparam int OVERSAMPLE = 16;

  // Receiver frame states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Clocks per oversample tick, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side bus of the UART receiver: pop request, show-ahead head byte,
// occupancy flags and the one-cycle error pulses.
interface uart_rx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);

  logic                              rd_en;
  logic [DATA_BITS-1:0]              rd_data;
  logic                              empty;
  logic                              full;
  logic [$clog2(FIFO_DEPTH+1)-1:0]   count;
  logic                              frame_err;
  logic                              overrun;

  // Consumer side.
  modport master (
    output rd_en,
    input  rd_data, empty, full, count, frame_err, overrun
  );

  // Receiver side.
  modport slave (
    input  rd_en,
    output rd_data, empty, full, count, frame_err, overrun
  );

endinterface

// File: rtl/sync_fifo.sv
// Show-ahead circular FIFO with explicit occupancy count. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; otherwise it is
// dropped and overrun_o pulses for one cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             push_data_i,
  input  logic                         pop_req_i,
  output logic [WIDTH-1:0]             rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         overrun_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             full_q;
  logic             empty_q;
  logic             overrun_q;
  logic             pop;
  logic             wr;

  // Accept/pop decisions and next occupancy; a pop on an empty FIFO is ignored.
  always_comb begin
    pop     = pop_req_i && !empty_q;
    wr      = push_i && (!full_q || pop);
    count_d = count_q;
    if (wr && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers (wrapping naturally), count and flags kept consistent with it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q   <= count_d;
      full_q    <= (count_d == CW'(DEPTH));
      empty_q   <= (count_d == '0);
      overrun_q <= push_i && !wr;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a show-ahead byte FIFO.
// Flags stop-bit framing errors and bytes lost to a full FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk_clk,
  input  logic          reset_reset_n,
  input  logic          rxd,
  uart_rx_fifo_if.slave bus
);

  localparam int DIV   = calc_div(CLK_HZ, BAUD);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  logic                 rx_meta_q;
  logic                 rx_s_q;
  rx_state_e            state_q, state_d;
  logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 push_q, push_d;
  logic                 frame_err_q, frame_err_d;

  // Two-flop synchroniser for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Oversample tick: held at zero while idle so its phase follows the start edge.
  always_comb begin
    tick = (state_q != IDLE) && (tick_cnt_q == DIV_W'(DIV - 1));
    if (state_q == IDLE || tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + DIV_W'(1);
    end
  end

  // Frame FSM: validate start at mid-bit, sample data and stop at bit centres.
  always_comb begin
    state_d     = state_q;
    os_cnt_d    = os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (!rx_s_q) begin
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
            os_cnt_d = '0;
            if (!rx_s_q) begin
              state_d   = DATA;
              bit_cnt_d = '0;
            end else begin
              // Too short to be a start bit: drop silently.
              state_d = IDLE;
            end
          end else begin
            os_cnt_d = os_cnt_q + OS_W'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              state_d = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_cnt_d = os_cnt_q + OS_W'(1);
          if (os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
            if (rx_s_q) begin
              push_d  = 1'b1;
              state_d = IDLE;
            end else begin
              frame_err_d = 1'b1;
              state_d     = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        // A held-low line (break) must not look like a fresh start bit.
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
    end
  end

  // shift_q holds the completed byte until the next frame's first data sample,
  // so it can be written one clock after the stop sample without a copy.
  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i       (clk_clk),
    .rst_ni      (reset_reset_n),
    .push_i      (push_q),
    .push_data_i (shift_q),
    .pop_req_i   (bus.rd_en),
    .rd_data_o   (bus.rd_data),
    .count_o     (bus.count),
    .full_o      (bus.full),
    .empty_o     (bus.empty),
    .overrun_o   (bus.overrun)
  );

  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed vector table, hand-written corner
// sequences, and random frames/pops checked against a queue model.
module tb_uart_rx_fifo;

  // Clock scaled so one bit is 64 clocks (DIV=4) to keep the run short.
  localparam int CLK_HZ     = 7372800;
  localparam int BAUD       = 115200;
  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int DIV        = 4;
  localparam int BIT        = 16 * DIV;
  // Clocks from driving the start edge to the cycle in which the FIFO write
  // happens: 2 sync + 1 detect, then 8+16*8+16 ticks, write on the next clock.
  localparam int PUSH_CYC   = 3 + DIV * (8 + 16 * DATA_BITS + 16);
  // Glitch kept below half a bit, like 200 clocks against 216 at defaults.
  localparam int GLITCH     = 24;

  localparam int OP_SEND   = 0;
  localparam int OP_POP    = 1;
  localparam int OP_GLITCH = 2;

  typedef struct {
    int         op;
    logic [7:0] data;
    logic       stop;
    int         hold;
    int         idle;
    int         exp_cnt;
    logic [7:0] exp_head;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  logic clk_clk = 1'b0;
  logic reset_reset_n;
  logic rxd;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;

  vec_t vecs[14];
  logic [7:0] model_q[$];

  always #5 clk_clk = ~clk_clk;

  uart_rx_fifo_if #(.DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH)) u_if ();

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .DATA_BITS  (DATA_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .rxd           (rxd),
    .bus           (u_if)
  );

  // Count cycles in which each error pulse is high.
  always @(negedge clk_clk) begin
    if (u_if.frame_err === 1'b1) fe_cnt++;
    if (u_if.overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: time limit reached, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int exp_cnt, input logic [7:0] exp_head);
    check({tag, " count"}, 32'(u_if.count), exp_cnt);
    check({tag, " empty"}, 32'(u_if.empty), 32'(exp_cnt == 0));
    check({tag, " full"}, 32'(u_if.full), 32'(exp_cnt == FIFO_DEPTH));
    if (exp_cnt > 0) check({tag, " head"}, 32'(u_if.rd_data), 32'(exp_head));
  endtask

  task automatic check_reset(input string tag);
    check({tag, " count"}, 32'(u_if.count), 0);
    check({tag, " empty"}, 32'(u_if.empty), 1);
    check({tag, " full"}, 32'(u_if.full), 0);
    check({tag, " rd_data"}, 32'(u_if.rd_data), 0);
    check({tag, " frame_err"}, 32'(u_if.frame_err), 0);
    check({tag, " overrun"}, 32'(u_if.overrun), 0);
  endtask

  // Drive one 8N1 frame from the current negedge; optionally keep the line
  // low after a bad stop bit, then idle high.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_bits,
                            input int idle_bits);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk_clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk_clk);
    end
    rxd = stop;
    repeat (BIT) @(negedge clk_clk);
    if (!stop) repeat (hold_bits * BIT) @(negedge clk_clk);
    rxd = 1'b1;
    repeat (idle_bits * BIT) @(negedge clk_clk);
  endtask

  task automatic pop_one(input string tag, input logic [7:0] exp_b);
    check({tag, " pop data"}, 32'(u_if.rd_data), 32'(exp_b));
    $display("pop %s: data=%02h", tag, u_if.rd_data);
    u_if.rd_en = 1'b1;
    @(negedge clk_clk);
    u_if.rd_en = 1'b0;
  endtask

  initial begin
    int fe0, ov0, exp_cnt, exp_fe, exp_ov;
    logic [7:0] b;
    logic stop;
    int idle;

    // Directed vectors from an empty FIFO.
    vecs[0]  = '{OP_SEND,   8'h55, 1'b1, 0,      1,  1, 8'h55, 0, 0};
    vecs[1]  = '{OP_POP,    8'h55, 1'b1, 0,      0,  0, 8'h00, 0, 0};
    vecs[2]  = '{OP_SEND,   8'hA5, 1'b1, 0,      0,  1, 8'hA5, 0, 0};
    vecs[3]  = '{OP_SEND,   8'h3C, 1'b1, 0,      0,  2, 8'hA5, 0, 0};
    vecs[4]  = '{OP_SEND,   8'hFF, 1'b1, 0,      1,  3, 8'hA5, 0, 0};
    vecs[5]  = '{OP_POP,    8'hA5, 1'b1, 0,      0,  2, 8'h3C, 0, 0};
    vecs[6]  = '{OP_POP,    8'h3C, 1'b1, 0,      0,  1, 8'hFF, 0, 0};
    vecs[7]  = '{OP_POP,    8'hFF, 1'b1, 0,      0,  0, 8'h00, 0, 0};
    vecs[8]  = '{OP_SEND,   8'h42, 1'b0, 2,      10, 0, 8'h00, 1, 0};
    vecs[9]  = '{OP_SEND,   8'h42, 1'b1, 0,      1,  1, 8'h42, 0, 0};
    vecs[10] = '{OP_POP,    8'h42, 1'b1, 0,      0,  0, 8'h00, 0, 0};
    vecs[11] = '{OP_GLITCH, 8'h00, 1'b1, GLITCH, 2,  0, 8'h00, 0, 0};
    vecs[12] = '{OP_SEND,   8'h81, 1'b1, 0,      1,  1, 8'h81, 0, 0};
    vecs[13] = '{OP_POP,    8'h81, 1'b1, 0,      0,  0, 8'h00, 0, 0};

    rxd = 1'b1;
    u_if.rd_en = 1'b0;
    reset_reset_n = 1'b0;
    repeat (3) @(negedge clk_clk);
    check_reset("reset");
    $display("reset: count=%0d empty=%0b", u_if.count, u_if.empty);
    reset_reset_n = 1'b1;
    repeat (4) @(negedge clk_clk);

    // Table-driven vectors.
    for (int i = 0; i < 14; i++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      case (vecs[i].op)
        OP_SEND:  send_frame(vecs[i].data, vecs[i].stop, vecs[i].hold, vecs[i].idle);
        OP_POP:   pop_one($sformatf("vec%0d", i), vecs[i].data);
        default: begin
          rxd = 1'b0;
          repeat (vecs[i].hold) @(negedge clk_clk);
          rxd = 1'b1;
          repeat (vecs[i].idle * BIT) @(negedge clk_clk);
        end
      endcase
      check_state($sformatf("vec%0d", i), vecs[i].exp_cnt, vecs[i].exp_head);
      check($sformatf("vec%0d frame_err", i), fe_cnt - fe0, vecs[i].exp_fe);
      check($sformatf("vec%0d overrun", i), ov_cnt - ov0, vecs[i].exp_ov);
      $display("vec%0d: op=%0d data=%02h count=%0d fe=%0d ov=%0d", i, vecs[i].op,
               vecs[i].data, u_if.count, fe_cnt - fe0, ov_cnt - ov0);
    end

    // 17 bytes with no reads: fills at 16, the 17th overruns once.
    for (int i = 0; i < 17; i++) begin
      ov0 = ov_cnt;
      send_frame(8'(i), 1'b1, 0, 1);
      exp_cnt = (i + 1 < FIFO_DEPTH) ? i + 1 : FIFO_DEPTH;
      check_state($sformatf("fill%0d", i), exp_cnt, 8'h00);
      check($sformatf("fill%0d overrun", i), ov_cnt - ov0, (i == 16) ? 1 : 0);
      $display("fill byte %02h: count=%0d full=%0b ov=%0d", i, u_if.count, u_if.full,
               ov_cnt - ov0);
    end

    // Full FIFO: 0x77 lands in the same cycle as a pop, so it is accepted.
    ov0 = ov_cnt;
    fork
      send_frame(8'h77, 1'b1, 0, 1);
      begin
        repeat (PUSH_CYC) @(negedge clk_clk);
        u_if.rd_en = 1'b1;
        @(negedge clk_clk);
        u_if.rd_en = 1'b0;
      end
    join
    check_state("push+pop full", FIFO_DEPTH, 8'h01);
    check("push+pop full overrun", ov_cnt - ov0, 0);
    $display("push 77 with pop: count=%0d head=%02h", u_if.count, u_if.rd_data);
    for (int i = 1; i < 17; i++) begin
      pop_one($sformatf("drain%0d", i), (i == 16) ? 8'h77 : 8'(i));
    end
    check_state("drained", 0, 8'h00);

    // Reset in the middle of a frame with data buffered.
    send_frame(8'h12, 1'b1, 0, 1);
    check_state("pre-reset", 1, 8'h12);
    b = 8'h34;
    rxd = 1'b0;
    repeat (BIT) @(negedge clk_clk);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk_clk);
    end
    reset_reset_n = 1'b0;
    #1;
    check_reset("mid-frame reset");
    $display("mid-frame reset: count=%0d empty=%0b", u_if.count, u_if.empty);
    rxd = 1'b1;
    repeat (BIT) @(negedge clk_clk);
    reset_reset_n = 1'b1;
    repeat (2 * BIT) @(negedge clk_clk);
    check_state("post-reset", 0, 8'h00);
    send_frame(8'h5A, 1'b1, 0, 1);
    check_state("post-reset rx", 1, 8'h5A);
    pop_one("post-reset", 8'h5A);

    // Random frames, bad stops and pops against a queue model.
    for (int n = 0; n < 48; n++) begin
      fe0 = fe_cnt;
      ov0 = ov_cnt;
      exp_fe = 0;
      exp_ov = 0;
      if ($urandom_range(0, 99) < 70) begin
        b = 8'($urandom);
        stop = ($urandom_range(0, 7) != 0);
        idle = stop ? int'($urandom_range(0, 1)) : 1;
        send_frame(b, stop, 0, idle);
        if (!stop) exp_fe = 1;
        else if (model_q.size() < FIFO_DEPTH) model_q.push_back(b);
        else exp_ov = 1;
        $display("rand%0d: send %02h stop=%0b count=%0d", n, b, stop, u_if.count);
      end else if (model_q.size() > 0) begin
        pop_one($sformatf("rand%0d", n), model_q.pop_front());
      end else begin
        // Pop request on an empty FIFO must be ignored.
        u_if.rd_en = 1'b1;
        @(negedge clk_clk);
        u_if.rd_en = 1'b0;
        $display("rand%0d: pop on empty", n);
      end
      check_state($sformatf("rand%0d", n), model_q.size(),
                  (model_q.size() > 0) ? model_q[0] : 8'h00);
      check($sformatf("rand%0d frame_err", n), fe_cnt - fe0, exp_fe);
      check($sformatf("rand%0d overrun", n), ov_cnt - ov0, exp_ov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
